// File: rtl/stream_fifo_pkg.sv
// Shared helpers for stream_fifo: occupancy width, parameter checks and threshold compares.
package stream_fifo_pkg;

    function automatic int unsigned occ_width(input int unsigned depth);
        return 32'($clog2(depth)) + 32'd1;
    endfunction

    function automatic logic is_pow2(input int unsigned n);
        return (n >= 32'd2) && ((n & (n - 32'd1)) == 32'd0);
    endfunction

    function automatic logic afull_chk(input int unsigned count, input int unsigned th);
        return count >= th;
    endfunction

    function automatic logic aempty_chk(input int unsigned count, input int unsigned th);
        return count <= th;
    endfunction

endpackage

// File: rtl/stream_fifo_mem.sv
// Unreset FIFO storage: one synchronous write port, one combinational read port.
module stream_fifo_mem #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/stream_fifo.sv
// First-word-fall-through stream FIFO with registered occupancy and almost-full/empty flags.
// Optional synchronous flush port enabled by defining STREAM_FIFO_FLUSH_EN.
module stream_fifo
    import stream_fifo_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned AFULL_TH  = DEPTH - 2,
    parameter int unsigned AEMPTY_TH = 2
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
`ifdef STREAM_FIFO_FLUSH_EN
    input  logic                         i_flush,
`endif
    input  logic [WIDTH-1:0]             i_data,
    input  logic                         i_valid,
    output logic                         o_ready,
    output logic [WIDTH-1:0]             o_data,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic [occ_width(DEPTH)-1:0]  o_count,
    output logic                         o_afull,
    output logic                         o_aempty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = occ_width(DEPTH);

    if (!is_pow2(DEPTH)) begin : g_bad_depth
        $error("stream_fifo: DEPTH must be a power of two >= 2");
    end
    if (AFULL_TH > DEPTH) begin : g_bad_afull
        $error("stream_fifo: AFULL_TH must be within 0..DEPTH");
    end
    if (AEMPTY_TH > DEPTH) begin : g_bad_aempty
        $error("stream_fifo: AEMPTY_TH must be within 0..DEPTH");
    end

    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          w_flush;
    logic          w_push;
    logic          w_pop;

`ifdef STREAM_FIFO_FLUSH_EN
    assign w_flush = i_flush;
`else
    assign w_flush = 1'b0;
`endif

    // Flush wins over both sides: ready drops so no push is accepted.
    assign o_ready  = (r_count != CW'(DEPTH)) && !w_flush;
    assign o_valid  = (r_count != '0);
    assign w_push   = i_valid && o_ready;
    assign w_pop    = o_valid && i_ready && !w_flush;
    assign o_count  = r_count;
    assign o_afull  = afull_chk(32'(r_count), AFULL_TH);
    assign o_aempty = aempty_chk(32'(r_count), AEMPTY_TH);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (w_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    stream_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .i_clk   (i_clk),
        .i_we    (w_push),
        .i_waddr (r_wptr),
        .i_wdata (i_data),
        .i_raddr (r_rptr),
        .o_rdata (o_data)
    );

endmodule

// File: tb/tb_stream_fifo.sv
// Self-checking bench for stream_fifo against a queue-based reference model.
// Flush scenario runs only when STREAM_FIFO_FLUSH_EN is defined.
module tb_stream_fifo;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic             i_clk;
    logic             i_rst;
    logic             i_flush;
    logic [WIDTH-1:0] i_data;
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] o_data;
    logic             o_valid;
    logic             i_ready;
    logic [CW-1:0]    o_count;
    logic             o_afull;
    logic             o_aempty;

    int checks = 0;
    int errors = 0;
    logic [WIDTH-1:0] q[$];

    stream_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
`ifdef STREAM_FIFO_FLUSH_EN
        .i_flush  (i_flush),
`endif
        .i_data   (i_data),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .o_data   (o_data),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_count  (o_count),
        .o_afull  (o_afull),
        .o_aempty (o_aempty)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every visible output with what the queue model implies.
    task automatic check_model(input string tag);
        int n;
        n = q.size();
        chk({tag, ".valid"},  32'(o_valid),  32'(n != 0));
        chk({tag, ".ready"},  32'(o_ready),  32'(n != DEPTH));
        chk({tag, ".count"},  32'(o_count),  n);
        chk({tag, ".afull"},  32'(o_afull),  32'(n >= 6));
        chk({tag, ".aempty"}, 32'(o_aempty), 32'(n <= 2));
        if (n != 0) chk({tag, ".data"}, 32'(o_data), 32'(q[0]));
    endtask

    // Drive one cycle at the falling edge, apply model rules at the rising edge, check after.
    task automatic cycle(input logic v, input logic [WIDTH-1:0] d, input logic r, input string tag);
        logic push, pop;
        i_valid = v;
        i_data  = d;
        i_ready = r;
        push = v && (q.size() != DEPTH) && !i_flush;
        pop  = r && (q.size() != 0) && !i_flush;
        @(posedge i_clk);
        if (i_flush) q.delete();
        else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back(d);
        end
        @(negedge i_clk);
        i_valid = 1'b0;
        i_ready = 1'b0;
        check_model(tag);
    endtask

    initial begin
        logic [WIDTH-1:0] held;
        logic [WIDTH-1:0] exp_q[$];
        i_flush = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_data  = '0;
        i_rst   = 1'b0;
        repeat (2) @(negedge i_clk);
        check_model("reset");
        i_rst = 1'b1;
        @(negedge i_clk);

        // Fill to full with the sink stalled; 9th push must be refused.
        for (int i = 0; i < 8; i++) cycle(1'b1, WIDTH'(i), 1'b0, "fill");
        chk("full.ready", 32'(o_ready), 32'd0);
        chk("full.afull", 32'(o_afull), 32'd1);
        cycle(1'b1, 8'hAA, 1'b0, "push_full");
        chk("push_full.count", 32'(o_count), 32'd8);

        // Drain in order.
        for (int i = 0; i < 8; i++) begin
            chk("drain.order", 32'(o_data), 32'(i));
            cycle(1'b0, '0, 1'b1, "drain");
        end
        chk("drained.valid", 32'(o_valid), 32'd0);
        chk("drained.count", 32'(o_count), 32'd0);

        // Steady streaming at count 3 across pointer wrap.
        for (int i = 0; i < 3; i++) cycle(1'b1, WIDTH'(8'h40 + i), 1'b0, "prime");
        for (int i = 0; i < 40; i++) begin
            chk("stream.delayed", 32'(o_data), 32'(8'h40 + i));
            cycle(1'b1, WIDTH'(8'h43 + i), 1'b1, "stream");
            chk("stream.count3", 32'(o_count), 32'd3);
        end
        while (q.size() != 0) cycle(1'b0, '0, 1'b1, "stream_drain");

        // Backpressure hold, then a single pop advances by one entry.
        cycle(1'b1, 8'h5A, 1'b0, "bp_push");
        cycle(1'b1, 8'hA5, 1'b0, "bp_push");
        held = o_data;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, '0, 1'b0, "bp_hold");
            chk("bp.stable", 32'(o_data), 32'(8'h5A));
            chk("bp.held", 32'(o_valid), 32'd1);
        end
        cycle(1'b0, '0, 1'b1, "bp_pop");
        chk("bp.advance", 32'(o_data), 32'(8'hA5));
        chk("bp.count", 32'(o_count), 32'd1);
        if (held !== 8'h5A) chk("bp.first", 32'(held), 32'(8'h5A));

        // Random traffic against the model.
        for (int i = 0; i < 400; i++)
            cycle(1'($urandom_range(0, 1)), WIDTH'($urandom), 1'($urandom_range(0, 2) != 0), "rand");

        // Asynchronous reset mid-stream at count 5.
        while (q.size() != 0) cycle(1'b0, '0, 1'b1, "pre_rst_drain");
        for (int i = 0; i < 5; i++) cycle(1'b1, WIDTH'(8'h90 + i), 1'b0, "pre_rst");
        chk("pre_rst.count", 32'(o_count), 32'd5);
        #2 i_rst = 1'b0;
        #1;
        q.delete();
        chk("rst.valid",  32'(o_valid),  32'd0);
        chk("rst.ready",  32'(o_ready),  32'd1);
        chk("rst.count",  32'(o_count),  32'd0);
        chk("rst.aempty", 32'(o_aempty), 32'd1);
        @(negedge i_clk);
        i_rst = 1'b1;
        cycle(1'b1, 8'hC3, 1'b0, "post_rst");
        chk("post_rst.head", 32'(o_data), 32'(8'hC3));

`ifdef STREAM_FIFO_FLUSH_EN
        // Flush with a concurrent push: the push must be dropped.
        for (int i = 0; i < 3; i++) cycle(1'b1, WIDTH'(8'hD0 + i), 1'b0, "pre_flush");
        chk("pre_flush.count", 32'(o_count), 32'd4);
        i_flush = 1'b1;
        i_valid = 1'b1;
        i_data  = 8'hEE;
        #1 chk("flush.ready", 32'(o_ready), 32'd0);
        cycle(1'b1, 8'hEE, 1'b1, "flush");
        i_flush = 1'b0;
        chk("flush.count", 32'(o_count), 32'd0);
        chk("flush.valid", 32'(o_valid), 32'd0);
        cycle(1'b1, 8'h11, 1'b0, "post_flush");
        chk("post_flush.head", 32'(o_data), 32'(8'h11));
        cycle(1'b0, '0, 1'b1, "post_flush_pop");
        chk("post_flush.absent", 32'(o_valid), 32'd0);
`endif

        exp_q.delete();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
